// File: rtl/datapath_pkg.sv
// Shared widths and encodings for the single-bus CPU datapath.
// Holds the bus-source priority enum and the ALU operation enum.
package datapath_pkg;

    localparam int WORD_W  = 32;
    localparam int SHAMT_W = 5;

    // Declaration order is the bus priority order (first match wins).
    typedef enum logic [3:0] {
        BUS_NONE,
        BUS_PC,
        BUS_ZHI,
        BUS_ZLO,
        BUS_MDR,
        BUS_HI,
        BUS_LO,
        BUS_INPORT,
        BUS_C,
        BUS_R2,
        BUS_R3,
        BUS_R4,
        BUS_R5,
        BUS_R7
    } bus_src_e;

    typedef enum logic [1:0] {
        ALU_PASS,
        ALU_INC,
        ALU_SHL
    } alu_op_e;

endpackage

// File: rtl/datapath_reg32.sv
// reg32: 32-bit register with load enable and synchronous active-low clear.
// Ports: clk, clr (active-low), i_ld, i_d[32] -> o_q[32].
module reg32
    import datapath_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              i_ld,
    input  logic [WORD_W-1:0] i_d,
    output logic [WORD_W-1:0] o_q
);

    logic [WORD_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_q <= '0;
        end else if (i_ld) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/cpu_datapath.sv
// cpu_datapath: single-bus 32-bit datapath (regfile, PC, IR, MAR, MDR,
// HI/LO, Y, 64-bit Z, ALU) sequenced one register transfer per clock.
// Ports: clk, clr (sync active-low), bus out-selects, load enables,
// Read, IncPC, SHL, MDatain[32], InPort_data[32].
// Define DATAPATH_DBG_EN to add state-mirror outputs (BusMuxOut, IR_q,
// MAR_q, PC_q, R1_q, Zlow_q, Zhigh_q).
module cpu_datapath
    import datapath_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              PCout,
    input  logic              Zlowout,
    input  logic              Zhighout,
    input  logic              MDRout,
    input  logic              HIout,
    input  logic              LOout,
    input  logic              InPortout,
    input  logic              Cout,
    input  logic              R2out,
    input  logic              R3out,
    input  logic              R4out,
    input  logic              R5out,
    input  logic              R7out,
    input  logic              R1in,
    input  logic              R2in,
    input  logic              R3in,
    input  logic              PCin,
    input  logic              IRin,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              Yin,
    input  logic              Zin,
    input  logic              HIin,
    input  logic              LOin,
    input  logic              Read,
    input  logic              IncPC,
    input  logic              SHL,
    input  logic [WORD_W-1:0] MDatain,
    input  logic [WORD_W-1:0] InPort_data
`ifdef DATAPATH_DBG_EN
    ,
    output logic [WORD_W-1:0] BusMuxOut,
    output logic [WORD_W-1:0] IR_q,
    output logic [WORD_W-1:0] MAR_q,
    output logic [WORD_W-1:0] PC_q,
    output logic [WORD_W-1:0] R1_q,
    output logic [WORD_W-1:0] Zlow_q,
    output logic [WORD_W-1:0] Zhigh_q
`endif
);

    logic [WORD_W-1:0] w_r [16];
    logic [15:0]       w_rin;
    logic [WORD_W-1:0] w_pc, w_ir, w_mar, w_mdr;
    logic [WORD_W-1:0] w_hi, w_lo, w_y;
    logic [WORD_W-1:0] w_zlo, w_zhi;
    logic [WORD_W-1:0] w_bus, w_c, w_mdr_d;
    logic [WORD_W-1:0] w_alu_lo;
    bus_src_e          w_src;
    alu_op_e           w_op;
    logic              w_unused;

    // Only R1-R3 have load ports; the rest stay at their reset value.
    assign w_rin = {12'b0, R3in, R2in, R1in, 1'b0};

    for (genvar i = 0; i < 16; i++) begin : g_r
        reg32 u_r (
            .clk (clk),
            .clr (clr),
            .i_ld(w_rin[i]),
            .i_d (w_bus),
            .o_q (w_r[i])
        );
    end

    assign w_mdr_d = Read ? MDatain : w_bus;

    reg32 u_pc  (.clk(clk), .clr(clr), .i_ld(PCin),  .i_d(w_bus),    .o_q(w_pc));
    reg32 u_ir  (.clk(clk), .clr(clr), .i_ld(IRin),  .i_d(w_bus),    .o_q(w_ir));
    reg32 u_mar (.clk(clk), .clr(clr), .i_ld(MARin), .i_d(w_bus),    .o_q(w_mar));
    reg32 u_mdr (.clk(clk), .clr(clr), .i_ld(MDRin), .i_d(w_mdr_d),  .o_q(w_mdr));
    reg32 u_hi  (.clk(clk), .clr(clr), .i_ld(HIin),  .i_d(w_bus),    .o_q(w_hi));
    reg32 u_lo  (.clk(clk), .clr(clr), .i_ld(LOin),  .i_d(w_bus),    .o_q(w_lo));
    reg32 u_y   (.clk(clk), .clr(clr), .i_ld(Yin),   .i_d(w_bus),    .o_q(w_y));
    reg32 u_zlo (.clk(clk), .clr(clr), .i_ld(Zin),   .i_d(w_alu_lo), .o_q(w_zlo));
    // No ALU op produces upper bits yet, so Zhigh always loads zero.
    reg32 u_zhi (.clk(clk), .clr(clr), .i_ld(Zin),   .i_d('0),       .o_q(w_zhi));

    assign w_c = {{13{w_ir[18]}}, w_ir[18:0]};

    // Several selects may be high at once, so this is a priority chain.
    always_comb begin
        w_src = BUS_NONE;
        if      (PCout)     w_src = BUS_PC;
        else if (Zhighout)  w_src = BUS_ZHI;
        else if (Zlowout)   w_src = BUS_ZLO;
        else if (MDRout)    w_src = BUS_MDR;
        else if (HIout)     w_src = BUS_HI;
        else if (LOout)     w_src = BUS_LO;
        else if (InPortout) w_src = BUS_INPORT;
        else if (Cout)      w_src = BUS_C;
        else if (R2out)     w_src = BUS_R2;
        else if (R3out)     w_src = BUS_R3;
        else if (R4out)     w_src = BUS_R4;
        else if (R5out)     w_src = BUS_R5;
        else if (R7out)     w_src = BUS_R7;
    end

    always_comb begin
        w_bus = '0;
        unique case (w_src)
            BUS_PC:     w_bus = w_pc;
            BUS_ZHI:    w_bus = w_zhi;
            BUS_ZLO:    w_bus = w_zlo;
            BUS_MDR:    w_bus = w_mdr;
            BUS_HI:     w_bus = w_hi;
            BUS_LO:     w_bus = w_lo;
            BUS_INPORT: w_bus = InPort_data;
            BUS_C:      w_bus = w_c;
            BUS_R2:     w_bus = w_r[2];
            BUS_R3:     w_bus = w_r[3];
            BUS_R4:     w_bus = w_r[4];
            BUS_R5:     w_bus = w_r[5];
            BUS_R7:     w_bus = w_r[7];
            default:    w_bus = '0;
        endcase
    end

    always_comb begin
        w_op = ALU_PASS;
        if      (IncPC) w_op = ALU_INC;
        else if (SHL)   w_op = ALU_SHL;
    end

    always_comb begin
        w_alu_lo = w_bus;
        unique case (w_op)
            ALU_INC: w_alu_lo = w_bus + 32'd1;
            ALU_SHL: w_alu_lo = w_y << w_bus[SHAMT_W-1:0];
            default: w_alu_lo = w_bus;
        endcase
    end

    // Registers that are held but not yet read by any datapath path.
    assign w_unused = ^{w_r[0], w_r[1], w_r[6], w_r[8], w_r[9], w_r[10],
                        w_r[11], w_r[12], w_r[13], w_r[14], w_r[15],
                        w_mar, w_ir[31:19]};

`ifdef DATAPATH_DBG_EN
    assign BusMuxOut = w_bus;
    assign IR_q      = w_ir;
    assign MAR_q     = w_mar;
    assign PC_q      = w_pc;
    assign R1_q      = w_r[1];
    assign Zlow_q    = w_zlo;
    assign Zhigh_q   = w_zhi;
`endif

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed transfers from the
// test plan followed by random transfers against a transfer-level model.
module tb_cpu_datapath;

    typedef struct packed {
        logic clr;
        logic pcout, zlowout, zhighout, mdrout, hiout, loout;
        logic inportout, cout;
        logic r2out, r3out, r4out, r5out, r7out;
        logic r1in, r2in, r3in;
        logic pcin, irin, marin, mdrin, yin, zin, hiin, loin;
        logic read, incpc, shl;
        logic [31:0] mdatain;
        logic [31:0] inport;
    } ctl_t;

    logic clk = 1'b0;
    ctl_t c;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_r [16];
    logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_hi, m_lo, m_y, m_zlo, m_zhi;

`ifdef DATAPATH_DBG_EN
    logic [31:0] d_bus, d_ir, d_mar, d_pc, d_r1, d_zlo, d_zhi;
`endif

    cpu_datapath dut (
        .clk        (clk),
        .clr        (c.clr),
        .PCout      (c.pcout),
        .Zlowout    (c.zlowout),
        .Zhighout   (c.zhighout),
        .MDRout     (c.mdrout),
        .HIout      (c.hiout),
        .LOout      (c.loout),
        .InPortout  (c.inportout),
        .Cout       (c.cout),
        .R2out      (c.r2out),
        .R3out      (c.r3out),
        .R4out      (c.r4out),
        .R5out      (c.r5out),
        .R7out      (c.r7out),
        .R1in       (c.r1in),
        .R2in       (c.r2in),
        .R3in       (c.r3in),
        .PCin       (c.pcin),
        .IRin       (c.irin),
        .MARin      (c.marin),
        .MDRin      (c.mdrin),
        .Yin        (c.yin),
        .Zin        (c.zin),
        .HIin       (c.hiin),
        .LOin       (c.loin),
        .Read       (c.read),
        .IncPC      (c.incpc),
        .SHL        (c.shl),
        .MDatain    (c.mdatain),
        .InPort_data(c.inport)
`ifdef DATAPATH_DBG_EN
        ,
        .BusMuxOut  (d_bus),
        .IR_q       (d_ir),
        .MAR_q      (d_mar),
        .PC_q       (d_pc),
        .R1_q       (d_r1),
        .Zlow_q     (d_zlo),
        .Zhigh_q    (d_zhi)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_c();
        if (m_ir[18]) return m_ir | 32'hFFF8_0000;
        return m_ir & 32'h0007_FFFF;
    endfunction

    function automatic logic [31:0] model_bus();
        logic        s [13];
        logic [31:0] v [13];
        s = '{c.pcout, c.zhighout, c.zlowout, c.mdrout, c.hiout, c.loout,
              c.inportout, c.cout, c.r2out, c.r3out, c.r4out, c.r5out,
              c.r7out};
        v = '{m_pc, m_zhi, m_zlo, m_mdr, m_hi, m_lo, c.inport, model_c(),
              m_r[2], m_r[3], m_r[4], m_r[5], m_r[7]};
        for (int i = 0; i < 13; i++) begin
            if (s[i]) return v[i];
        end
        return 32'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_r[i] = 32'h0;
        m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0;
        m_hi = 0; m_lo = 0; m_y = 0; m_zlo = 0; m_zhi = 0;
    endtask

    task automatic check_state(input string p);
        chk({p, "_pc"},  dut.w_pc,  m_pc);
        chk({p, "_ir"},  dut.w_ir,  m_ir);
        chk({p, "_mar"}, dut.w_mar, m_mar);
        chk({p, "_mdr"}, dut.w_mdr, m_mdr);
        chk({p, "_hi"},  dut.w_hi,  m_hi);
        chk({p, "_lo"},  dut.w_lo,  m_lo);
        chk({p, "_y"},   dut.w_y,   m_y);
        chk({p, "_zlo"}, dut.w_zlo, m_zlo);
        chk({p, "_zhi"}, dut.w_zhi, m_zhi);
        chk({p, "_r1"},  dut.w_r[1], m_r[1]);
        chk({p, "_r2"},  dut.w_r[2], m_r[2]);
        chk({p, "_r3"},  dut.w_r[3], m_r[3]);
        chk({p, "_r4"},  dut.w_r[4], m_r[4]);
        chk({p, "_r5"},  dut.w_r[5], m_r[5]);
        chk({p, "_r7"},  dut.w_r[7], m_r[7]);
    endtask

    // One transfer: check the bus mid-cycle, clock it, check all state.
    task automatic step(input string p);
        logic [31:0] b, z;
        #2;
        b = model_bus();
        chk({p, "_bus"}, dut.w_bus, b);
        if (c.incpc)    z = b + 1;
        else if (c.shl) z = m_y << (b % 32);
        else            z = b;
        @(posedge clk);
        #1;
        if (!c.clr) begin
            model_reset();
        end else begin
            if (c.r1in)  m_r[1] = b;
            if (c.r2in)  m_r[2] = b;
            if (c.r3in)  m_r[3] = b;
            if (c.pcin)  m_pc = b;
            if (c.irin)  m_ir = b;
            if (c.marin) m_mar = b;
            if (c.mdrin) m_mdr = c.read ? c.mdatain : b;
            if (c.yin)   m_y = b;
            if (c.hiin)  m_hi = b;
            if (c.loin)  m_lo = b;
            if (c.zin) begin
                m_zlo = z;
                m_zhi = 0;
            end
        end
        check_state(p);
    endtask

    task automatic idle();
        c = '0;
        c.clr = 1'b1;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        idle(); c.mdatain = v; c.read = 1; c.mdrin = 1; step("ldmdr");
    endtask

    initial begin
        model_reset();
        c = '0;
        step("rst");
        chk("rst_pc_zero", dut.w_pc, 32'h0);

        load_mdr(32'hDB);
        idle(); c.mdrout = 1; c.r2in = 1; step("r2ld");
        chk("r2_db", dut.w_r[2], 32'hDB);

        load_mdr(32'h2);
        idle(); c.mdrout = 1; c.r3in = 1; step("r3ld");
        idle(); c.r2out = 1; c.yin = 1; step("shy");
        idle(); c.r3out = 1; c.shl = 1; c.zin = 1; step("shz");
        chk("shl_zlo", dut.w_zlo, 32'h36C);
        chk("shl_zhi", dut.w_zhi, 32'h0);
        idle(); c.zlowout = 1; c.r1in = 1; step("shr1");
        chk("shl_r1", dut.w_r[1], 32'h36C);

        idle(); c.clr = 0; step("rst2");
        idle(); c.pcout = 1; c.marin = 1; c.incpc = 1; c.zin = 1;
        step("t0");
        idle(); c.zlowout = 1; c.pcin = 1; c.read = 1; c.mdrin = 1;
        c.mdatain = 32'h2891_8000; step("t1");
        idle(); c.mdrout = 1; c.irin = 1; step("t2");
        chk("fetch_mar", dut.w_mar, 32'h0);
        chk("fetch_pc", dut.w_pc, 32'h1);
        chk("fetch_ir", dut.w_ir, 32'h2891_8000);

        load_mdr(32'h0007_FFFF);
        idle(); c.mdrout = 1; c.irin = 1; step("irc");
        idle(); c.cout = 1; #2;
        chk("c_sext", dut.w_bus, 32'hFFFF_FFFF);
        step("cbus");

        load_mdr(32'h1);
        idle(); c.mdrout = 1; c.yin = 1; step("y1");
        load_mdr(32'd33);
        idle(); c.mdrout = 1; c.shl = 1; c.zin = 1; step("shmask");
        chk("shl_mask", dut.w_zlo, 32'h2);

        load_mdr(32'hFFFF_FFFF);
        idle(); c.mdrout = 1; c.incpc = 1; c.zin = 1; step("wrap");
        chk("inc_wrap", dut.w_zlo, 32'h0);

        idle(); #2;
        chk("bus_idle", dut.w_bus, 32'h0);
        step("idle");
        idle(); c.pcout = 1; c.mdrout = 1; #2;
        chk("bus_prio", dut.w_bus, 32'h1);
        step("prio");

        load_mdr(32'h5);
        idle(); c.mdrout = 1; c.pcin = 1; step("pc5");
        load_mdr(32'h7);
        idle(); c.mdrout = 1; c.r1in = 1; step("r17");
        idle(); c.clr = 0; c.pcin = 1; c.mdrout = 1; step("rstov");
        chk("rst_pc", dut.w_pc, 32'h0);
        chk("rst_r1", dut.w_r[1], 32'h0);
        chk("rst_z", dut.w_zlo | dut.w_zhi, 32'h0);

        for (int k = 0; k < 400; k++) begin
            c = '0;
            c.clr       = ($urandom_range(0, 24) != 0);
            c.pcout     = ($urandom_range(0, 9) == 0);
            c.zlowout   = ($urandom_range(0, 6) == 0);
            c.zhighout  = ($urandom_range(0, 12) == 0);
            c.mdrout    = ($urandom_range(0, 4) == 0);
            c.hiout     = ($urandom_range(0, 7) == 0);
            c.loout     = ($urandom_range(0, 7) == 0);
            c.inportout = ($urandom_range(0, 5) == 0);
            c.cout      = ($urandom_range(0, 6) == 0);
            c.r2out     = ($urandom_range(0, 5) == 0);
            c.r3out     = ($urandom_range(0, 5) == 0);
            c.r4out     = ($urandom_range(0, 9) == 0);
            c.r5out     = ($urandom_range(0, 9) == 0);
            c.r7out     = ($urandom_range(0, 9) == 0);
            c.r1in      = ($urandom_range(0, 2) == 0);
            c.r2in      = ($urandom_range(0, 2) == 0);
            c.r3in      = ($urandom_range(0, 2) == 0);
            c.pcin      = ($urandom_range(0, 3) == 0);
            c.irin      = ($urandom_range(0, 3) == 0);
            c.marin     = ($urandom_range(0, 3) == 0);
            c.mdrin     = ($urandom_range(0, 2) == 0);
            c.yin       = ($urandom_range(0, 2) == 0);
            c.zin       = ($urandom_range(0, 1) == 0);
            c.hiin      = ($urandom_range(0, 3) == 0);
            c.loin      = ($urandom_range(0, 3) == 0);
            c.read      = ($urandom_range(0, 1) == 0);
            c.incpc     = ($urandom_range(0, 3) == 0);
            c.shl       = ($urandom_range(0, 2) == 0);
            c.mdatain   = $urandom;
            c.inport    = $urandom;
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
